// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
// Shared definitions for the multiply/divide unit and the CPU decoder:
//   - MDOp operation-code constants
//   - FSM state type (IDLE, BUSY)
//   - helpers that classify an opcode as a multi-cycle multiply or divide
// Build option: defining MULT_DIV_UNIT_MADD_EN makes the accumulate opcodes
// (MADD/MADDU/MSUB/MSUBU) multi-cycle operations. Otherwise they are no-ops.
package mult_div_unit_pkg;

    localparam logic [3:0] MD_MULT  = 4'b0000;
    localparam logic [3:0] MD_MULTU = 4'b0001;
    localparam logic [3:0] MD_DIV   = 4'b0010;
    localparam logic [3:0] MD_DIVU  = 4'b0011;
    localparam logic [3:0] MD_MTHI  = 4'b0100;
    localparam logic [3:0] MD_MTLO  = 4'b0101;
    localparam logic [3:0] MD_MADD  = 4'b0110;
    localparam logic [3:0] MD_MADDU = 4'b0111;
    localparam logic [3:0] MD_MSUB  = 4'b1000;
    localparam logic [3:0] MD_MSUBU = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Opcodes that use the multiply latency.
    function automatic logic md_is_mult(input logic [3:0] op);
        logic hit;
        hit = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MULT_DIV_UNIT_MADD_EN
        hit = hit || (op == MD_MADD) || (op == MD_MADDU) ||
                     (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return hit;
    endfunction

    // Opcodes that use the divide latency.
    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit
// HI/LO multiply/divide unit with fixed, counter-modelled latency.
// Arithmetic is behavioural. The down-counter only times when the
// result is committed to HI/LO.
// Ports:
//   clk      in   1      clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   A, B     in   WIDTH  operands (rs, rt)
//   MDOp     in   4      operation code (see mult_div_unit_pkg)
//   start    in   1      issue strobe. MDOp/A/B are sampled when it is high.
//   cancel   in   1      flush. It aborts the in-flight operation, and a start
//                        on the same edge in IDLE is ignored.
//   busy     out  1      operation in flight
//   HI, LO   out  WIDTH  architectural HI/LO registers
// Build option: MULT_DIV_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into {HI,LO}). When it is undefined, those codes are no-ops.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDOp,
    input  logic             start,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    md_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [3:0]       op_reg,    op_next;
    logic [WIDTH-1:0] a_reg,     a_next;
    logic [WIDTH-1:0] b_reg,     b_next;
    logic [WIDTH-1:0] hi_reg,    hi_next;
    logic [WIDTH-1:0] lo_reg,    lo_next;

    // ------------------------------------------------------------------
    // Datapath on the latched operands
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_u, prod_s;
    logic [WIDTH-1:0]   quo_u, rem_u, quo_s, rem_s;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // The signed product is taken as an unsigned product of sign-extended
    // operands. The low 2*WIDTH bits are the exact two's-complement result.
    assign prod_u = {{WIDTH{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_reg};
    assign prod_s = {{WIDTH{a_reg[WIDTH-1]}}, a_reg} * {{WIDTH{b_reg[WIDTH-1]}}, b_reg};

    // Signed / and % truncate toward zero, so the remainder follows the
    // dividend. Divide-by-zero and overflow are overridden in the mux below.
    assign quo_u = a_reg / b_reg;
    assign rem_u = a_reg % b_reg;
    assign quo_s = $signed(a_reg) / $signed(b_reg);
    assign rem_s = $signed(a_reg) % $signed(b_reg);

`ifdef MULT_DIV_UNIT_MADD_EN
    logic [2*WIDTH-1:0] acc;
    assign acc = {hi_reg, lo_reg};
`endif

    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (op_reg)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                if (b_reg == '0) begin
                    res_hi = a_reg;
                    res_lo = ALL_ONES;
                end else if (a_reg == MOST_NEG && b_reg == ALL_ONES) begin
                    res_hi = '0;
                    res_lo = MOST_NEG;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MD_DIVU: begin
                if (b_reg == '0) begin
                    res_hi = a_reg;
                    res_lo = ALL_ONES;
                end else begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
`ifdef MULT_DIV_UNIT_MADD_EN
            MD_MADD:  {res_hi, res_lo} = acc + prod_s;
            MD_MADDU: {res_hi, res_lo} = acc + prod_u;
            MD_MSUB:  {res_hi, res_lo} = acc - prod_s;
            MD_MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                // A flush on the issue edge kills the issue, and this includes MTHI/MTLO.
                if (start && !cancel) begin
                    if (md_is_mult(MDOp) || md_is_div(MDOp)) begin
                        state_next = BUSY;
                        op_next    = MDOp;
                        a_next     = A;
                        b_next     = B;
                        count_next = md_is_div(MDOp) ? CNT_W'(DIV_CYCLES)
                                                     : CNT_W'(MULT_CYCLES);
                    end else if (MDOp == MD_MTHI) begin
                        hi_next = A;
                    end else if (MDOp == MD_MTLO) begin
                        lo_next = A;
                    end
                end
            end
            BUSY: begin
                // The counter holds the number of busy cycles still to go.
                // The edge that sees 1 is the last one, and it commits the result.
                // Cancel takes priority over a completion on the same edge.
                if (cancel) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg <= CNT_W'(1)) begin
                    state_next = IDLE;
                    count_next = '0;
                    hi_next    = res_hi;
                    lo_next    = res_lo;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy = (state_reg == BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, operand/HI/LO width.
- MULT_CYCLES, 5, multiply latency in cycles (>=1).
- DIV_CYCLES, 10, divide latency in cycles (>=1).
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- A  in  WIDTH  operand 1 (rs).
- B  in  WIDTH  operand 2 (rt).
- MDOp  in  4  operation code.
- start  in  1  issue strobe; MDOp/A/B sampled when high.
- cancel  in  1  abort in-flight operation (exception flush).
- busy  out  1  operation in flight.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Function
REQ-003 MDOp encodings SHALL be:
- MULT 0000, MULTU 0001, DIV 0010, DIVU 0011, MTHI 0100, MTLO 0101.
- MADD 0110, MADDU 0111, MSUB 1000, MSUBU 1001.
- All other codes are no-ops.
REQ-004 FSM SHALL have two states.
- IDLE -> BUSY on start with a mult/div/accumulate op, cancel low.
- BUSY -> IDLE when the counter expires or cancel is high.
REQ-005 busy SHALL equal (state == BUSY), registered; it rises the cycle after the start edge.
REQ-006 On accept, operands and op SHALL be latched and a down-counter loaded with MULT_CYCLES (mult/accumulate) or DIV_CYCLES (div).
REQ-007 busy SHALL stay high exactly N cycles; HI/LO SHALL update on the edge that drops busy.
REQ-008 MULT/MULTU SHALL produce {HI,LO} = signed/unsigned 2*WIDTH-bit product.
REQ-009 DIV/DIVU SHALL set LO = quotient and HI = remainder.
- Signed quotient truncates toward zero; remainder takes the dividend's sign.
REQ-010 Divide by zero SHALL set LO = all ones and HI = A (dividend).
REQ-011 Signed DIV of most-negative / -1 SHALL set LO = most-negative and HI = 0.
REQ-012 MTHI/MTLO SHALL write A into HI/LO on the start edge with zero latency; busy stays low.
REQ-013 start while BUSY SHALL be ignored; latched operands are unaffected.
REQ-014 cancel in BUSY SHALL return the FSM to IDLE next edge and leave HI/LO unchanged.
REQ-015 start and cancel high together in IDLE SHALL be ignored, including MTHI/MTLO.
REQ-016 HI/LO SHALL change only per REQ-007, REQ-012 and reset.

Reset
REQ-017 reset_n low SHALL immediately force state IDLE, busy 0, HI 0, LO 0, counter 0 and latched operands 0.
REQ-018 Reset during BUSY SHALL discard the operation; no HI/LO update follows release.
REQ-019 The first start SHALL be accepted on the first rising clk edge after reset_n deasserts.

Configuration
REQ-020 Macro MULT_DIV_UNIT_MADD_EN SHALL gate the accumulate ops.
- Defined: MADD/MADDU do {HI,LO} += product; MSUB/MSUBU do {HI,LO} -= product.
- Defined: accumulate ops are signed/unsigned per name, wrap modulo 2^(2*WIDTH), and take MULT_CYCLES latency.
- Undefined: codes 0110-1001 are no-ops, busy stays low, and no accumulate datapath is synthesised.

Structure
REQ-021 Package mult_div_unit_pkg SHALL hold the MDOp encoding constants and the FSM state typedef (IDLE, BUSY); the CPU decoder shares them.
REQ-022 Arithmetic SHALL be inline (behavioural * / %) with no sub-module; the counter only models latency.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- MULT A=0xFFFFFFFE, B=3 -> busy 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIVU A=100, B=7 -> busy 10 cycles; LO=14, HI=2. DIV A=-7, B=2 -> LO=-3, HI=-1.
- DIV A=5, B=0 -> LO=0xFFFFFFFF, HI=5. DIV A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- MULT start, then a second start on cycle 2, then cancel on cycle 3 -> busy low cycle 4; HI/LO hold prior values.
- MTLO A=0x1234 in IDLE -> LO=0x1234 next edge, busy 0. reset_n low mid-DIV -> HI=LO=0, busy 0 asynchronously.
- With MULT_DIV_UNIT_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0. Without it: same stimulus -> busy 0, HI/LO unchanged.
